// File: rtl/fib_pkg.sv
// fib_pkg: shared constants for the Fibonacci sequencer.
//   OP_*      command op-codes carried on cmd_op
//   SEED_RST  value loaded into a and b on reset and on CLEAR
//   state_t   sequencer FSM states
package fib_pkg;

  localparam logic [1:0] OP_SEED_A = 2'd0;
  localparam logic [1:0] OP_SEED_B = 2'd1;
  localparam logic [1:0] OP_STEP   = 2'd2;
  localparam logic [1:0] OP_CLEAR  = 2'd3;

  localparam int unsigned SEED_RST = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/fib_core.sv
// fib_core: Fibonacci recurrence datapath (register pair a, b and adder).
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (a = b = SEED_RST)
//   load_a       a <= din
//   load_b       b <= din
//   clear        a <= SEED_RST, b <= SEED_RST
//   step         a <= b, b <= (a + b) mod 2^WIDTH
//   din          seed value
//   a, b         current register values
//   carry        carry out of a + b (combinational, for the current a, b)
// Priority when several controls are high: clear, then step, then loads.
module fib_core
  import fib_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_a,
  input  logic             load_b,
  input  logic             clear,
  input  logic             step,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             carry
);

  localparam logic [WIDTH-1:0] SEED = WIDTH'(SEED_RST);

  // One extra bit so the wrap of the sum is visible as the carry.
  logic [WIDTH:0] sum;

  assign sum   = {1'b0, a} + {1'b0, b};
  assign carry = sum[WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a <= SEED;
      b <= SEED;
    end else if (clear) begin
      a <= SEED;
      b <= SEED;
    end else if (step) begin
      a <= b;
      b <= sum[WIDTH-1:0];
    end else begin
      if (load_a) a <= din;
      if (load_b) b <= din;
    end
  end

endmodule

// File: rtl/fib_seq_ctrl.sv
// fib_seq_ctrl: command-driven sequencer for the Fibonacci datapath.
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; the sender holds valid and its payload until that edge, and
// ready never depends combinationally on valid.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake (ready only in IDLE)
//   cmd_op, cmd_data      op-code (fib_pkg OP_*) and seed / step count N
//   res_valid/res_ready   response handshake (valid only in RESP)
//   res_data, res_ovf     value of a after the run, and "any add wrapped"
//   busy                  high in RUN and RESP
//   cur_fib               live value of register a
module fib_seq_ctrl
  import fib_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_ovf,
  output logic             busy,
  output logic [WIDTH-1:0] cur_fib
);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               ovf, ovf_nxt;

  logic               load_a, load_b, clear, step;
  logic [WIDTH-1:0]   a, b;
  logic               carry;

  fib_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_a (load_a),
    .load_b (load_b),
    .clear  (clear),
    .step   (step),
    .din    (cmd_data),
    .a      (a),
    .b      (b),
    .carry  (carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      ovf   <= ovf_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ovf_nxt   = ovf;
    load_a    = 1'b0;
    load_b    = 1'b0;
    clear     = 1'b0;
    step      = 1'b0;
    cmd_ready = 1'b0;
    res_valid = 1'b0;

    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          case (cmd_op)
            OP_SEED_A: load_a = 1'b1;
            OP_SEED_B: load_b = 1'b1;
            OP_CLEAR: begin
              clear   = 1'b1;
              ovf_nxt = 1'b0;
            end
            default: begin // OP_STEP
              ovf_nxt = 1'b0;
              cnt_nxt = cmd_data[CNT_W-1:0];
              // N = 0 answers at once with a unchanged.
              state_nxt = (cmd_data[CNT_W-1:0] == '0) ? RESP : RUN;
            end
          endcase
        end
      end

      RUN: begin
        // One step per cycle; the step taken while cnt == 1 is the last one.
        step    = 1'b1;
        ovf_nxt = ovf | carry;
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_nxt = RESP;
      end

      RESP: begin
        res_valid = 1'b1;
        if (res_ready) state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign res_data = a;
  assign res_ovf  = ovf;
  assign busy     = (state != IDLE);
  assign cur_fib  = a;

endmodule

// File: tb/tb_fib_seq_ctrl.sv
module tb_fib_seq_ctrl;
  import fib_pkg::*;

  localparam int WIDTH = 8;
  localparam int CNT_W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'd0;
  logic [WIDTH-1:0] cmd_data = '0;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [WIDTH-1:0] res_data;
  logic             res_ovf;
  logic             busy;
  logic [WIDTH-1:0] cur_fib;

  fib_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_ovf   (res_ovf),
    .busy      (busy),
    .cur_fib   (cur_fib)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- driver tasks ----------------
  // Offers one command from a negedge and returns just after the accept edge.
  task automatic send_cmd(input logic [1:0] op, input logic [WIDTH-1:0] data);
    bit done = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    for (int i = 0; i < 60 && !done; i++) begin
      if (cmd_ready) begin
        @(posedge clk);
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    check("cmd_accept_timeout", 32'(done), 32'd1);
    #1 cmd_valid = 1'b0;
  endtask

  // Waits for res_valid, checks latency (edges after accept) and payload,
  // then completes the handshake and checks return to IDLE.
  task automatic wait_resp(input string name, input int exp_lat,
                           input logic [WIDTH-1:0] exp_data, input logic exp_ovf);
    int lat = 0;
    bit seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (res_valid) seen = 1'b1;
      else lat++;
    end
    check({name, "_resp_seen"}, 32'(seen), 32'd1);
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    check({name, "_res_data"}, 32'(res_data), 32'(exp_data));
    check({name, "_res_ovf"}, 32'(res_ovf), 32'(exp_ovf));
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    @(negedge clk);
    check({name, "_idle_cmd_ready"}, 32'(cmd_ready), 32'd1);
    check({name, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]       op;
    logic [WIDTH-1:0] data;
    bit               resp;     // STEP: a response is expected
    logic [WIDTH-1:0] exp_a;    // res_data for STEP, cur_fib otherwise
    logic             exp_ovf;
  } vec_t;

  vec_t vecs[6];

  logic [WIDTH-1:0] trace10[11];

  initial begin
    int ones;

    // CLEAR then STEP 12: a=233, b wraps 377->121.  STEP 1: a=121, 233+121 wraps.
    // SEED 2,1 then STEP 5: Lucas 2,1,3,4,7,11,18 -> a=11.
    vecs[0] = '{OP_CLEAR,  8'd0,  1'b0, 8'd1,   1'b0};
    vecs[1] = '{OP_STEP,   8'd12, 1'b1, 8'd233, 1'b1};
    vecs[2] = '{OP_STEP,   8'd1,  1'b1, 8'd121, 1'b1};
    vecs[3] = '{OP_SEED_A, 8'd2,  1'b0, 8'd2,   1'b0};
    vecs[4] = '{OP_SEED_B, 8'd1,  1'b0, 8'd2,   1'b0};
    vecs[5] = '{OP_STEP,   8'd5,  1'b1, 8'd11,  1'b0};

    trace10 = '{8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13, 8'd21, 8'd34, 8'd55, 8'd89};

    // ---- reset values ----
    #12;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cur_fib", 32'(cur_fib), 32'd1);
    check("rst_res_data", 32'(res_data), 32'd1);
    check("rst_res_ovf", 32'(res_ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ---- STEP 10 from reset with live cur_fib trace ----
    send_cmd(OP_STEP, 8'd10);
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      check($sformatf("n10_cur_fib_%0d", k), 32'(cur_fib), 32'(trace10[k]));
      check($sformatf("n10_res_valid_%0d", k), 32'(res_valid), 32'(k == 10));
      if (k < 10) check($sformatf("n10_busy_%0d", k), 32'(busy), 32'd1);
    end
    check("n10_res_data", 32'(res_data), 32'd89);
    check("n10_res_ovf", 32'(res_ovf), 32'd0);
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;

    // ---- table-driven vectors ----
    for (int i = 0; i < 6; i++) begin
      send_cmd(vecs[i].op, vecs[i].data);
      if (vecs[i].resp) begin
        wait_resp($sformatf("vec%0d", i), int'(vecs[i].data), vecs[i].exp_a, vecs[i].exp_ovf);
      end else begin
        @(negedge clk);
        check($sformatf("vec%0d_cur_fib", i), 32'(cur_fib), 32'(vecs[i].exp_a));
        check($sformatf("vec%0d_no_resp", i), 32'(res_valid), 32'd0);
      end
    end

    // ---- STEP 0 with held-off response (a=11, b=18) ----
    send_cmd(OP_STEP, 8'd0);
    @(negedge clk);
    check("n0_res_valid", 32'(res_valid), 32'd1);
    check("n0_res_data", 32'(res_data), 32'd11);
    check("n0_res_ovf", 32'(res_ovf), 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("n0_hold_valid_%0d", k), 32'(res_valid), 32'd1);
      check($sformatf("n0_hold_data_%0d", k), 32'(res_data), 32'd11);
      check($sformatf("n0_hold_ovf_%0d", k), 32'(res_ovf), 32'd0);
      check($sformatf("n0_hold_cmd_ready_%0d", k), 32'(cmd_ready), 32'd0);
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;

    // ---- SEED_A offered during RUN: STEP 3 from (11,18) -> 18,29,47 ----
    send_cmd(OP_STEP, 8'd3);
    cmd_valid = 1'b1;
    cmd_op    = OP_SEED_A;
    cmd_data  = 8'd7;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("blk_cmd_ready_%0d", k), 32'(cmd_ready), 32'd0);
      check($sformatf("blk_cur_fib_%0d", k), 32'(cur_fib), 32'(k == 0 ? 11 : (k == 1 ? 18 : 29)));
    end
    @(negedge clk);
    check("blk_res_valid", 32'(res_valid), 32'd1);
    check("blk_res_data", 32'(res_data), 32'd47);
    check("blk_res_ovf", 32'(res_ovf), 32'd0);
    check("blk_resp_cmd_ready", 32'(cmd_ready), 32'd0);
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    @(negedge clk);
    // Response edge must not also accept the held command.
    check("blk_after_resp_cur_fib", 32'(cur_fib), 32'd47);
    check("blk_after_resp_cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    check("blk_seed_a_applied", 32'(cur_fib), 32'd7);
    check("blk_seed_no_resp", 32'(res_valid), 32'd0);

    // ---- reset mid-RUN: STEP 20, abort after 6 steps ----
    send_cmd(OP_STEP, 8'd20);
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_cur_fib", 32'(cur_fib), 32'd1);
    check("mid_rst_b", 32'(dut.u_core.b), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_res_valid", 32'(res_valid), 32'd0);
    check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ones = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (res_valid || busy) ones++;
    end
    check("post_rst_no_stale_resp", 32'(ones), 32'd0);

    // ---- sequence continues normally after reset: 1,1,2 ----
    send_cmd(OP_STEP, 8'd2);
    wait_resp("post_rst_n2", 2, 8'd2, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
